// File: rtl/bbc_keyboard_scan.sv
// rtl/bbc_keyboard_scan.sv - BBC keyboard matrix, column scanner and VIA PA7/CA2 drive
module bbc_keyboard_scan #(
    parameter int          SCAN_DIV = 2,
    parameter logic [7:0]  LINKS    = 8'h00
) (
    input  logic       PHI_2,
    input  logic       nRESET,
    input  logic       nKBEN,
    input  logic [6:0] PA_IN,
    output logic       PA7,
    output logic       CA2,
    input  logic       KEY_STROBE,
    input  logic       KEY_DOWN,
    input  logic [2:0] KEY_ROW,
    input  logic [3:0] KEY_COL,
    input  logic       ALL_UP,
    output logic [3:0] COLUMN
);

    // Row 0 only stores SHIFT/CTRL; its columns 2..9 are the fixed link inputs.
    logic [1:0]      mod_q, mod_d;
    logic [7:1][9:0] key_q, key_d;
    logic [3:0]      col_q, col_d;
    logic [7:0]      pre_q, pre_d;
    logic            ca2_q, ca2_d;

    logic [2:0]      row_sel;
    logic [2:0]      link_idx;

    always_ff @(posedge PHI_2 or negedge nRESET) begin
        if (!nRESET) begin
            mod_q <= '0;
            key_q <= '0;
            col_q <= '0;
            pre_q <= '0;
            ca2_q <= 1'b0;
        end else begin
            mod_q <= mod_d;
            key_q <= key_d;
            col_q <= col_d;
            pre_q <= pre_d;
            ca2_q <= ca2_d;
        end
    end

    // ALL_UP clears first so a simultaneous strobe still lands.
    always_comb begin
        mod_d = ALL_UP ? '0 : mod_q;
        key_d = ALL_UP ? '0 : key_q;
        if (KEY_STROBE && (KEY_COL <= 4'd9)) begin
            if (KEY_ROW == 3'd0) begin
                if (KEY_COL < 4'd2) begin
                    mod_d[KEY_COL[0]] = KEY_DOWN;
                end
            end else begin
                key_d[KEY_ROW][KEY_COL] = KEY_DOWN;
            end
        end
    end

    always_comb begin
        col_d = col_q;
        pre_d = pre_q;
        if (nKBEN) begin
            col_d = PA_IN[3:0];
            pre_d = '0;
        end else if (pre_q == 8'(SCAN_DIV - 1)) begin
            pre_d = '0;
            col_d = col_q + 4'd1;
        end else begin
            pre_d = pre_q + 8'd1;
        end
    end

    always_comb begin
        ca2_d = 1'b0;
        if (col_q <= 4'd9) begin
            for (int r = 1; r < 8; r++) begin
                ca2_d = ca2_d | key_q[r][col_q];
            end
        end
    end

    // PA7 is combinational so the VIA sampling at negedge sees the current column.
    always_comb begin
        row_sel  = PA_IN[6:4];
        link_idx = 3'(4'd9 - col_q);
        PA7      = 1'b0;
        if (row_sel == 3'd0) begin
            if ((col_q >= 4'd2) && (col_q <= 4'd9)) begin
                PA7 = LINKS[link_idx];
            end else if (col_q < 4'd2) begin
                PA7 = mod_q[col_q[0]];
            end
        end else if (col_q <= 4'd9) begin
            PA7 = key_q[row_sel][col_q];
        end
    end

    assign CA2    = ca2_q;
    assign COLUMN = col_q;

endmodule

// File: doc/bbc_keyboard_scan.md
Name: bbc_keyboard_scan

Overview:
- Keyboard matrix and column-scan logic that sits directly upstream of the system VIA.
- Holds the 10x8 key matrix, written by a key-event interface from the host-keyboard decoder.
- Drives VIA PA7 (key-at-address pressed) and VIA CA2 (key-in-column interrupt request).
- When autoscan is enabled, a free-running 4-bit column counter sweeps the matrix. When it is disabled, the VIA selects the column and row directly through PORTA.

Parameters:
- SCAN_DIV, 2: number of PHI_2 cycles per column-counter advance in autoscan. Range 1..255.
- LINKS, 8'h00: startup DIP link values, read back in matrix row 0, columns 2..9.

Ports:
- PHI_2, input, 1: system clock. All state changes on posedge.
- nRESET, input, 1: asynchronous, active-low reset.
- nKBEN, input, 1: keyboard enable from the addressable latch. 0 = autoscan runs; 1 = counter loads PA_IN[3:0] every cycle.
- PA_IN, input, 7: VIA PORTA[6:0]. [3:0] = column, [6:4] = row.
- PA7, output, 1: matrix bit at row PA_IN[6:4] and the current column.
- CA2, output, 1: registered OR of rows 1..7 of the current column.
- KEY_STROBE, input, 1: single-cycle key event qualifier.
- KEY_DOWN, input, 1: with KEY_STROBE. 1 = press (set bit), 0 = release (clear bit).
- KEY_ROW, input, 3: event row 0..7.
- KEY_COL, input, 4: event column 0..15.
- ALL_UP, input, 1: release every key (host keyboard reset or resync).
- COLUMN, output, 4: current column counter value, for debug and the LED/latch logic.

Behaviour:
- Reset (async, nRESET=0):
  - key matrix all 0; column counter = 0; prescaler = 0; CA2 = 0.
  - PA7 follows the combinational rule, and so reads 0 for key positions and the LINKS value for link positions.
- Matrix: 8 rows x 10 columns of key bits (columns 0..9).
  - Row 0, columns 2..9 are not stored. They read LINKS[9-col] and are constant.
  - Row 0, columns 0..1 (SHIFT, CTRL) are stored keys.
- Key event, on posedge when KEY_STROBE=1:
  - bit[KEY_ROW][KEY_COL] <= KEY_DOWN.
  - Ignored when KEY_COL > 9, or when the target is a row-0 link position (column 2..9).
  - The new value is visible to PA7 and the CA2 logic from the next cycle.
- ALL_UP=1 clears all stored bits.
  - If KEY_STROBE is active in the same cycle, the clear is applied first and then the event. The strobed key ends at KEY_DOWN; all other keys end at 0.
- Column counter:
  - nKBEN=1: counter <= PA_IN[3:0] every cycle; prescaler <= 0.
  - nKBEN=0: prescaler counts 0..SCAN_DIV-1. In the cycle it equals SCAN_DIV-1 it wraps to 0 and the counter increments.
  - The counter wraps 15 -> 0. Columns 10..15 are empty: all bits read 0, including row 0.
  - When nKBEN goes 1->0, counting resumes from the last loaded value with the prescaler at 0.
- PA7 is combinational, with no clock latency, so the VIA read at negedge PHI_2 sees the current state.
  - PA7 = bit[PA_IN[6:4]][COLUMN].
  - PA7 = 0 when COLUMN > 9, except that row-0 link positions always return their LINKS value.
  - When nKBEN=1, COLUMN equals the PA_IN[3:0] registered the previous cycle. PA7 is therefore valid one PHI_2 after PA_IN changes.
- CA2 is registered: CA2 <= OR(bit[1..7][COLUMN]).
  - Row 0 (modifiers and links) never contributes.
  - CA2 is 0 for columns 10..15.
  - Evaluation is the same in both nKBEN modes. The VIA PCR selects the edge it interrupts on.
- COLUMN = column counter register.
- A reset asserted mid-scan or mid-event aborts immediately and returns all state to the reset values. No event is buffered.

Test Plan:
- Reset, then nKBEN=1, PA_IN=7'h00; check PA7=0 and CA2=0. Read row 0 for columns 2..9 with LINKS=8'hA5 -> PA7 returns 1,0,1,0,0,1,0,1 for columns 2..9 (LINKS[7] first).
- KEY_STROBE with DOWN=1, ROW=3, COL=5. With nKBEN=1 and PA_IN=7'h35, PA7=1 two cycles later and CA2=1. Release the key -> PA7=0 and CA2=0 on the following cycles.
- Autoscan, SCAN_DIV=2, key held at row 2 col 7: COLUMN advances every 2 cycles and wraps 15->0. CA2 is high only for the 2 cycles after COLUMN==7, with a period of 32 cycles.
- Press SHIFT (row 0, col 0) in autoscan -> CA2 stays 0; PA7=1 when PA_IN=7'h00 and nKBEN=1.
- Press several keys, then assert ALL_UP together with a strobe press of row 4 col 9 -> only row 4 col 9 reads 1. A strobe with KEY_COL=12, and a strobe to row 0 col 4, leave the matrix unchanged.
- Assert nRESET low mid-autoscan with keys held -> COLUMN=0 and CA2=0 immediately; all key reads return 0 after release.
